// File: rtl/vend_pkg.sv
// Shared constants for the vending transaction sequencer: state codes, coin values and button bit map.
// Pure declarations; no timing or flow-control behaviour of its own.
package vend_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PAY    = 3'd1;
    localparam logic [2:0] ST_DISP   = 3'd2;
    localparam logic [2:0] ST_CHANGE = 3'd3;
    localparam logic [2:0] ST_REFUND = 3'd4;

    localparam logic [4:0] COIN1  = 5'd1;
    localparam logic [4:0] COIN2  = 5'd2;
    localparam logic [4:0] COIN5  = 5'd5;
    localparam logic [4:0] COIN10 = 5'd10;

    localparam int BTN_C1  = 2;
    localparam int BTN_C2  = 4;
    localparam int BTN_C5  = 1;
    localparam int BTN_C10 = 0;
    localparam int BTN_OK  = 3;

    localparam int N_PROD = 4;

    // Zero means "no coin": either no coin bit or more than one coin bit was pressed.
    function automatic logic [4:0] coin_value(input logic [4:0] btn);
        logic [3:0] c;
        c = {btn[BTN_C10], btn[BTN_C5], btn[BTN_C2], btn[BTN_C1]};
        case (c)
            4'b0001: coin_value = COIN1;
            4'b0010: coin_value = COIN2;
            4'b0100: coin_value = COIN5;
            4'b1000: coin_value = COIN10;
            default: coin_value = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Up-counter with synchronous clear/enable; expire is asserted combinationally while the count equals limit.
// Zero latency from count to expire; no backpressure, the owner decides when to clear.
module vend_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = en && (cnt_q == limit);

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: select -> pay -> dispense -> change, one purchase in flight, owns stock.
// All outputs registered (1-cycle from input); change_vld holds until change_ack.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE0      = 12,
    parameter int PRICE1      = 14,
    parameter int PRICE2      = 2,
    parameter int PRICE3      = 3,
    parameter int STOCK_INIT  = 2,
    parameter int TIMEOUT_CYC = 1000,
    parameter int DISP_CYC    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sel,
    input  logic [4:0]  btn_edge,
    input  logic        change_ack,
    output logic [2:0]  state,
    output logic [1:0]  prod,
    output logic [4:0]  remain,
    output logic [4:0]  paid,
    output logic [4:0]  change,
    output logic        change_vld,
    output logic        dispense,
    output logic        sold_out,
    output logic [15:0] stock
);

    localparam int TMAX = (TIMEOUT_CYC > DISP_CYC) ? TIMEOUT_CYC : DISP_CYC;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] T_PAY  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] T_DISP = TW'(DISP_CYC - 1);

    function automatic logic [4:0] price_of(input logic [1:0] p);
        case (p)
            2'd0:    price_of = 5'(PRICE0);
            2'd1:    price_of = 5'(PRICE1);
            2'd2:    price_of = 5'(PRICE2);
            default: price_of = 5'(PRICE3);
        endcase
    endfunction

    logic [2:0] state_q, state_d;
    logic [1:0] prod_q, prod_d;
    logic [4:0] remain_q, remain_d;
    logic [4:0] paid_q, paid_d;
    logic [4:0] change_q, change_d;
    logic       change_vld_q, change_vld_d;
    logic       dispense_q, dispense_d;
    logic       sold_out_q, sold_out_d;
    logic [3:0] stock_q [N_PROD];
    logic [3:0] stock_d [N_PROD];

    logic       ok;
    logic [4:0] coin_v;
    logic       coin_hit;
    logic       sel_onehot;
    logic [1:0] sel_idx;
    logic [4:0] price;
    logic [4:0] sum;
    logic       tmr_clr;
    logic       tmr_en;
    logic       tmr_exp;
    logic [TW-1:0] tmr_limit;

    assign ok         = btn_edge[BTN_OK];
    assign coin_v     = coin_value(btn_edge);
    assign coin_hit   = (coin_v != 5'd0);
    assign sel_onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    assign price      = price_of(prod_q);
    assign sum        = paid_q + coin_v;

    // sel[3] is product 0, so the index is the reversed bit position.
    always_comb begin
        case (sel)
            4'b1000: sel_idx = 2'd0;
            4'b0100: sel_idx = 2'd1;
            4'b0010: sel_idx = 2'd2;
            default: sel_idx = 2'd3;
        endcase
    end

    assign tmr_en    = (state_q == ST_PAY) || (state_q == ST_DISP);
    assign tmr_limit = (state_q == ST_DISP) ? T_DISP : T_PAY;

    vend_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .limit  (tmr_limit),
        .expire (tmr_exp)
    );

    always_comb begin
        state_d    = state_q;
        prod_d     = prod_q;
        remain_d   = remain_q;
        paid_d     = paid_q;
        change_d   = change_q;
        sold_out_d = 1'b0;
        tmr_clr    = 1'b0;
        stock_d    = stock_q;

        case (state_q)
            ST_IDLE: begin
                if (ok && sel_onehot) begin
                    if (stock_q[sel_idx] != 4'd0) begin
                        prod_d   = sel_idx;
                        remain_d = price_of(sel_idx);
                        paid_d   = 5'd0;
                        state_d  = ST_PAY;
                    end else begin
                        sold_out_d = 1'b1;
                    end
                end
            end
            ST_PAY: begin
                // A valid coin in the same cycle as confirm takes priority.
                if (coin_hit) begin
                    tmr_clr = 1'b1;
                    paid_d  = sum;
                    if (sum >= price) begin
                        state_d          = ST_DISP;
                        remain_d         = 5'd0;
                        change_d         = sum - price;
                        stock_d[prod_q]  = stock_q[prod_q] - 4'd1;
                    end else begin
                        remain_d = price - sum;
                    end
                end else if (ok || tmr_exp) begin
                    state_d  = ST_REFUND;
                    change_d = paid_q;
                end
            end
            ST_DISP: begin
                if (tmr_exp) begin
                    if (change_q != 5'd0) begin
                        state_d = ST_CHANGE;
                    end else begin
                        state_d  = ST_IDLE;
                        paid_d   = 5'd0;
                        remain_d = 5'd0;
                    end
                end
            end
            ST_CHANGE, ST_REFUND: begin
                if (change_ack || (state_q == ST_REFUND && change_q == 5'd0)) begin
                    state_d  = ST_IDLE;
                    change_d = 5'd0;
                    paid_d   = 5'd0;
                    remain_d = 5'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            tmr_clr = 1'b1;
        end
    end

    assign dispense_d   = (state_d == ST_DISP);
    assign change_vld_d = (state_d == ST_CHANGE) || ((state_d == ST_REFUND) && (change_d != 5'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prod_q       <= 2'd0;
            remain_q     <= 5'd0;
            paid_q       <= 5'd0;
            change_q     <= 5'd0;
            change_vld_q <= 1'b0;
            dispense_q   <= 1'b0;
            sold_out_q   <= 1'b0;
            for (int i = 0; i < N_PROD; i++) begin
                stock_q[i] <= 4'(STOCK_INIT);
            end
        end else begin
            state_q      <= state_d;
            prod_q       <= prod_d;
            remain_q     <= remain_d;
            paid_q       <= paid_d;
            change_q     <= change_d;
            change_vld_q <= change_vld_d;
            dispense_q   <= dispense_d;
            sold_out_q   <= sold_out_d;
            for (int i = 0; i < N_PROD; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign state      = state_q;
    assign prod       = prod_q;
    assign remain     = remain_q;
    assign paid       = paid_q;
    assign change     = change_q;
    assign change_vld = change_vld_q;
    assign dispense   = dispense_q;
    assign sold_out   = sold_out_q;
    assign stock      = {stock_q[0], stock_q[1], stock_q[2], stock_q[3]};

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl; expected change amounts queued at stimulus time and popped on change_vld.
module tb_vend_txn_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel;
    logic [4:0]  btn_edge;
    logic        change_ack;
    logic [2:0]  state;
    logic [1:0]  prod;
    logic [4:0]  remain;
    logic [4:0]  paid;
    logic [4:0]  change;
    logic        change_vld;
    logic        dispense;
    logic        sold_out;
    logic [15:0] stock;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int n_disp;

    localparam logic [4:0] B_C1 = 5'b00100;
    localparam logic [4:0] B_C2 = 5'b10000;
    localparam logic [4:0] B_C5 = 5'b00010;
    localparam logic [4:0] B_C10 = 5'b00001;
    localparam logic [4:0] B_OK = 5'b01000;

    vend_txn_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .btn_edge   (btn_edge),
        .change_ack (change_ack),
        .state      (state),
        .prod       (prod),
        .remain     (remain),
        .paid       (paid),
        .change     (change),
        .change_vld (change_vld),
        .dispense   (dispense),
        .sold_out   (sold_out),
        .stock      (stock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        btn_edge = b;
        tick();
        btn_edge = 5'd0;
    endtask

    task automatic confirm(input logic [3:0] s);
        sel = s;
        press(B_OK);
    endtask

    // Counts dispense-high cycles starting from the current sample, bounded.
    task automatic count_disp(output int n);
        n = 0;
        for (int k = 0; k < 40 && dispense; k++) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_vld(input string tag);
        for (int k = 0; k < 40 && !change_vld; k++) tick();
        chk({tag, "_vld"}, change_vld, 1'b1);
        chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk({tag, "_change"}, change, exp_q.pop_front());
    endtask

    task automatic ack_and_check(input string tag);
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        chk({tag, "_ack_state"}, state, 3'd0);
        chk({tag, "_ack_change"}, change, 5'd0);
        chk({tag, "_ack_vld"}, change_vld, 1'b0);
        chk({tag, "_ack_paid"}, paid, 5'd0);
    endtask

    initial begin
        rst = 1'b1;
        sel = 4'd0;
        btn_edge = 5'd0;
        change_ack = 1'b0;
        #3;
        chk("rst_state", state, 3'd0);
        chk("rst_outs", {prod, remain, paid, change}, 17'd0);
        chk("rst_flags", {change_vld, dispense, sold_out}, 3'd0);
        chk("rst_stock", stock, 16'h2222);
        #9 rst = 1'b0;
        tick();

        // 1) product 0, 10+5 -> change 3
        confirm(4'b1000);
        chk("t1_state_pay", state, 3'd1);
        chk("t1_prod", prod, 2'd0);
        chk("t1_remain0", remain, 5'd12);
        press(B_C10);
        chk("t1_paid10", paid, 5'd10);
        chk("t1_remain2", remain, 5'd2);
        exp_q.push_back(3);
        press(B_C5);
        chk("t1_state_disp", state, 3'd2);
        chk("t1_paid15", paid, 5'd15);
        chk("t1_stock", stock, 16'h1222);
        count_disp(n_disp);
        chk("t1_disp_cycles", n_disp, 4);
        chk("t1_state_change", state, 3'd3);
        wait_vld("t1");
        ack_and_check("t1");
        chk("t1_remain_clr", remain, 5'd0);

        // 2) product 2, 1+1 -> exact payment, no change
        confirm(4'b0010);
        chk("t2_remain2", remain, 5'd2);
        press(B_C1);
        chk("t2_remain1", remain, 5'd1);
        press(B_C1);
        chk("t2_remain0", remain, 5'd0);
        chk("t2_state_disp", state, 3'd2);
        count_disp(n_disp);
        chk("t2_disp_cycles", n_disp, 4);
        chk("t2_state_idle", state, 3'd0);
        chk("t2_no_vld", change_vld, 1'b0);
        chk("t2_stock", stock, 16'h1212);

        // 3) product 1, 10 then cancel -> refund 10
        confirm(4'b0100);
        press(B_C10);
        exp_q.push_back(10);
        press(B_OK);
        chk("t3_state_refund", state, 3'd4);
        chk("t3_no_disp", dispense, 1'b0);
        wait_vld("t3");
        ack_and_check("t3");
        chk("t3_stock", stock, 16'h1212);

        // 4) product 3, coin2 then idle until timeout
        confirm(4'b0001);
        press(B_C2);
        chk("t4_paid2", paid, 5'd2);
        exp_q.push_back(2);
        for (int k = 0; k < 999; k++) tick();
        chk("t4_still_pay", state, 3'd1);
        tick();
        chk("t4_timeout_refund", state, 3'd4);
        wait_vld("t4");
        ack_and_check("t4");

        // 5) product 2 again, then sold out; multi-hot ignored
        confirm(4'b0010);
        press(B_C2);
        count_disp(n_disp);
        chk("t5_disp_cycles", n_disp, 4);
        chk("t5_stock", stock, 16'h1202);
        confirm(4'b0010);
        chk("t5_sold_out", sold_out, 1'b1);
        chk("t5_state_idle", state, 3'd0);
        tick();
        chk("t5_sold_out_pulse", sold_out, 1'b0);
        confirm(4'b1100);
        chk("t5_multihot_state", state, 3'd0);
        chk("t5_multihot_sold", sold_out, 1'b0);

        // 6) multi-coin dropped, coin beats confirm, reset mid-PAY
        confirm(4'b1000);
        press(5'b00011);
        chk("t6_multicoin_paid", paid, 5'd0);
        chk("t6_multicoin_state", state, 3'd1);
        press(B_OK | B_C5);
        chk("t6_coin_wins_paid", paid, 5'd5);
        chk("t6_coin_wins_state", state, 3'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_state", state, 3'd0);
        chk("t6_rst_outs", {prod, remain, paid, change}, 17'd0);
        chk("t6_rst_stock", stock, 16'h2222);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t6_sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
